// File: rtl/ddr3_dfi_init_seq.sv
// DDR3 power-up / initialisation sequencer for the GW2A DFI PHY.
// Walks the reset -> CKE -> MRS2/3/1/0 -> ZQCL -> PHY config sequence with a
// single down-counter, then hands the DFI command bus to the controller
// through a registered pass-through.
module ddr3_dfi_init_seq #(
  parameter int unsigned          ADDR_BITS = 14,
  parameter int unsigned          RD_LAT    = 4,
  parameter int unsigned          T_RESET   = 20000,
  parameter int unsigned          T_CKE     = 50000,
  parameter int unsigned          T_XPR     = 16,
  parameter int unsigned          T_MRD     = 4,
  parameter int unsigned          T_MOD     = 12,
  parameter int unsigned          T_ZQINIT  = 512,
  parameter logic [ADDR_BITS-1:0] MR0       = 'h0520,
  parameter logic [ADDR_BITS-1:0] MR1       = 'h0004,
  parameter logic [ADDR_BITS-1:0] MR2       = 'h0000,
  parameter logic [ADDR_BITS-1:0] MR3       = 'h0000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 restart_i,
  input  logic                 ctl_cs_n_i,
  input  logic                 ctl_ras_n_i,
  input  logic                 ctl_cas_n_i,
  input  logic                 ctl_we_n_i,
  input  logic                 ctl_odt_i,
  input  logic [2:0]           ctl_bank_i,
  input  logic [ADDR_BITS-1:0] ctl_address_i,
  output logic                 ctl_ready_o,
  output logic                 dfi_reset_n_o,
  output logic                 dfi_cke_o,
  output logic                 dfi_cs_n_o,
  output logic                 dfi_ras_n_o,
  output logic                 dfi_cas_n_o,
  output logic                 dfi_we_n_o,
  output logic                 dfi_odt_o,
  output logic [2:0]           dfi_bank_o,
  output logic [ADDR_BITS-1:0] dfi_address_o,
  output logic                 cfg_valid_o,
  output logic [31:0]          cfg_o,
  output logic                 init_done_o
);

  // 24 bits covers the 500 us CKE wait at 100 MHz with plenty of margin.
  localparam int unsigned CNT_W = 24;

  typedef enum logic [3:0] {
    S_RST, S_CKEW, S_XPR, S_MRS2, S_MRS3, S_MRS1, S_MRS0, S_ZQ, S_CFG, S_DONE
  } state_e;

  typedef struct packed {
    logic                 cs_n;
    logic                 ras_n;
    logic                 cas_n;
    logic                 we_n;
    logic                 odt;
    logic [2:0]           bank;
    logic [ADDR_BITS-1:0] addr;
  } cmd_t;

  localparam cmd_t CMD_DESEL = '{cs_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1,
                                 odt: 1'b0, bank: 3'd0, addr: '0};
  localparam cmd_t CMD_NOP   = '{cs_n: 1'b0, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1,
                                 odt: 1'b0, bank: 3'd0, addr: '0};
  localparam cmd_t CMD_ZQCL  = '{cs_n: 1'b0, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b0,
                                 odt: 1'b0, bank: 3'd0,
                                 addr: ADDR_BITS'(32'h0000_0400)};

  localparam logic [31:0] CFG_WORD = {20'b0, 4'(RD_LAT), 8'b0};

  // RST is entered on the reset/restart edge itself (cycle 0), so it loads
  // the full T_RESET to leave dfi_reset_n low through cycle T_RESET.
  localparam logic [CNT_W-1:0] LD_RESET  = CNT_W'(T_RESET);
  localparam logic [CNT_W-1:0] LD_CKE    = CNT_W'(T_CKE - 1);
  localparam logic [CNT_W-1:0] LD_XPR    = CNT_W'(T_XPR - 1);
  localparam logic [CNT_W-1:0] LD_MRD    = CNT_W'(T_MRD - 1);
  localparam logic [CNT_W-1:0] LD_MOD    = CNT_W'(T_MOD - 1);
  localparam logic [CNT_W-1:0] LD_ZQINIT = CNT_W'(T_ZQINIT - 1);

  function automatic cmd_t mrs_cmd(input logic [2:0] ba, input logic [ADDR_BITS-1:0] val);
    cmd_t c;
    c      = '{cs_n: 1'b0, ras_n: 1'b0, cas_n: 1'b0, we_n: 1'b0,
               odt: 1'b0, bank: 3'd0, addr: '0};
    c.bank = ba;
    c.addr = val;
    return c;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cmd_t             cmd_q, cmd_d;
  logic             dfi_reset_n_q, dfi_reset_n_d;
  logic             dfi_cke_q, dfi_cke_d;
  logic             cfg_valid_q, cfg_valid_d;
  logic [31:0]      cfg_q, cfg_d;
  logic             init_done_q, init_done_d;
  logic             entering;
  cmd_t             ctl_cmd;

  assign ctl_cmd = '{cs_n: ctl_cs_n_i, ras_n: ctl_ras_n_i, cas_n: ctl_cas_n_i,
                     we_n: ctl_we_n_i, odt: ctl_odt_i, bank: ctl_bank_i,
                     addr: ctl_address_i};

  // Next state, counter and next output values; outputs are decoded from the
  // next state so every output register lines up with the state register.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    cnt_d         = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
    dfi_reset_n_d = 1'b1;
    dfi_cke_d     = 1'b1;
    cmd_d         = CMD_NOP;
    cfg_valid_d   = 1'b0;
    cfg_d         = cfg_q;
    init_done_d   = 1'b0;

    unique case (state_q)
      S_RST:  if (cnt_q == '0) begin state_d = S_CKEW; cnt_d = LD_CKE;    end
      S_CKEW: if (cnt_q == '0) begin state_d = S_XPR;  cnt_d = LD_XPR;    end
      S_XPR:  if (cnt_q == '0) begin state_d = S_MRS2; cnt_d = LD_MRD;    end
      S_MRS2: if (cnt_q == '0) begin state_d = S_MRS3; cnt_d = LD_MRD;    end
      S_MRS3: if (cnt_q == '0) begin state_d = S_MRS1; cnt_d = LD_MRD;    end
      S_MRS1: if (cnt_q == '0) begin state_d = S_MRS0; cnt_d = LD_MOD;    end
      S_MRS0: if (cnt_q == '0) begin state_d = S_ZQ;   cnt_d = LD_ZQINIT; end
      S_ZQ:   if (cnt_q == '0) begin state_d = S_CFG;  cnt_d = '0;        end
      S_CFG:  state_d = S_DONE;
      S_DONE: if (restart_i)   begin state_d = S_RST;  cnt_d = LD_RESET;  end
      default: begin state_d = S_RST; cnt_d = LD_RESET; end
    endcase

    // Commands are issued only on the first cycle of their state.
    entering = (state_d != state_q);

    unique case (state_d)
      S_RST: begin
        dfi_reset_n_d = 1'b0;
        dfi_cke_d     = 1'b0;
        cmd_d         = CMD_DESEL;
      end
      S_CKEW: begin
        dfi_cke_d = 1'b0;
        cmd_d     = CMD_DESEL;
      end
      S_MRS2: if (entering) cmd_d = mrs_cmd(3'd2, MR2);
      S_MRS3: if (entering) cmd_d = mrs_cmd(3'd3, MR3);
      S_MRS1: if (entering) cmd_d = mrs_cmd(3'd1, MR1);
      S_MRS0: if (entering) cmd_d = mrs_cmd(3'd0, MR0);
      S_ZQ:   if (entering) cmd_d = CMD_ZQCL;
      S_CFG: begin
        cfg_valid_d = 1'b1;
        cfg_d       = CFG_WORD;
      end
      S_DONE: begin
        init_done_d = 1'b1;
        // The controller only sees ready from the first DONE cycle, so its
        // inputs are forwarded from the second DONE edge onwards.
        if (state_q == S_DONE) cmd_d = ctl_cmd;
      end
      default: ;
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_RST;
      cnt_q         <= LD_RESET;
      cmd_q         <= CMD_DESEL;
      dfi_reset_n_q <= 1'b0;
      dfi_cke_q     <= 1'b0;
      cfg_valid_q   <= 1'b0;
      cfg_q         <= '0;
      init_done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_q         <= cmd_d;
      dfi_reset_n_q <= dfi_reset_n_d;
      dfi_cke_q     <= dfi_cke_d;
      cfg_valid_q   <= cfg_valid_d;
      cfg_q         <= cfg_d;
      init_done_q   <= init_done_d;
    end
  end

  assign dfi_reset_n_o = dfi_reset_n_q;
  assign dfi_cke_o     = dfi_cke_q;
  assign dfi_cs_n_o    = cmd_q.cs_n;
  assign dfi_ras_n_o   = cmd_q.ras_n;
  assign dfi_cas_n_o   = cmd_q.cas_n;
  assign dfi_we_n_o    = cmd_q.we_n;
  assign dfi_odt_o     = cmd_q.odt;
  assign dfi_bank_o    = cmd_q.bank;
  assign dfi_address_o = cmd_q.addr;
  assign cfg_valid_o   = cfg_valid_q;
  assign cfg_o         = cfg_q;
  assign init_done_o   = init_done_q;
  assign ctl_ready_o   = init_done_q;

endmodule

// File: tb/tb_ddr3_dfi_init_seq.sv
// Self-checking bench for ddr3_dfi_init_seq: randomized controller traffic
// and restart pulses against a cycle-schedule reference model, plus a second
// instance with default timing for the long reset/CKE waits.
module tb_ddr3_dfi_init_seq;

  localparam int TR = 8, TC = 10, TX = 5, TMRD = 4, TMOD = 12, TZQ = 20;
  localparam logic [13:0] MR0_V = 14'h0520, MR1_V = 14'h0004;
  localparam logic [13:0] MR2_V = 14'h0000, MR3_V = 14'h0000;

  // Output schedule derived from the timing rules (cycle k after the
  // reset-release or restart edge sequence start).
  localparam int K_RST_UP = TR + 1;
  localparam int K_CKE_UP = K_RST_UP + TC;
  localparam int K_MR2    = K_CKE_UP + TX;
  localparam int K_MR3    = K_MR2 + TMRD;
  localparam int K_MR1    = K_MR3 + TMRD;
  localparam int K_MR0    = K_MR1 + TMRD;
  localparam int K_ZQ     = K_MR0 + TMOD;
  localparam int K_CFG    = K_ZQ + TZQ;
  localparam int K_DONE   = K_CFG + 1;
  localparam logic [31:0] CFG_WORD = 32'h0000_0400;

  typedef struct packed {
    logic        cs_n, ras_n, cas_n, we_n, odt;
    logic [2:0]  bank;
    logic [13:0] addr;
  } cmd_t;

  typedef struct packed {
    logic        rst_n, cke;
    cmd_t        cmd;
    logic        cfg_valid;
    logic [31:0] cfg;
    logic        done, ready;
  } obs_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n = 1'b0, restart_i = 1'b0;
  logic        ctl_cs_n_i = 1'b1, ctl_ras_n_i = 1'b1, ctl_cas_n_i = 1'b1;
  logic        ctl_we_n_i = 1'b1, ctl_odt_i = 1'b0;
  logic [2:0]  ctl_bank_i = '0;
  logic [13:0] ctl_address_i = '0;
  logic        ctl_ready_o, dfi_reset_n_o, dfi_cke_o, dfi_cs_n_o, dfi_ras_n_o;
  logic        dfi_cas_n_o, dfi_we_n_o, dfi_odt_o, cfg_valid_o, init_done_o;
  logic [2:0]  dfi_bank_o;
  logic [13:0] dfi_address_o;
  logic [31:0] cfg_o;

  ddr3_dfi_init_seq #(
    .T_RESET(TR), .T_CKE(TC), .T_XPR(TX), .T_MRD(TMRD), .T_MOD(TMOD), .T_ZQINIT(TZQ)
  ) dut (
    .clock(clock), .reset_n(reset_n), .restart_i(restart_i),
    .ctl_cs_n_i(ctl_cs_n_i), .ctl_ras_n_i(ctl_ras_n_i), .ctl_cas_n_i(ctl_cas_n_i),
    .ctl_we_n_i(ctl_we_n_i), .ctl_odt_i(ctl_odt_i), .ctl_bank_i(ctl_bank_i),
    .ctl_address_i(ctl_address_i), .ctl_ready_o(ctl_ready_o),
    .dfi_reset_n_o(dfi_reset_n_o), .dfi_cke_o(dfi_cke_o), .dfi_cs_n_o(dfi_cs_n_o),
    .dfi_ras_n_o(dfi_ras_n_o), .dfi_cas_n_o(dfi_cas_n_o), .dfi_we_n_o(dfi_we_n_o),
    .dfi_odt_o(dfi_odt_o), .dfi_bank_o(dfi_bank_o), .dfi_address_o(dfi_address_o),
    .cfg_valid_o(cfg_valid_o), .cfg_o(cfg_o), .init_done_o(init_done_o)
  );

  // Default-timing instance, used only for the long waits.
  logic        d_reset_n = 1'b0;
  logic        d_ready, d_reset_n_o, d_cke, d_cs_n, d_ras_n, d_cas_n, d_we_n, d_odt;
  logic        d_cfg_valid, d_done;
  logic [2:0]  d_bank;
  logic [13:0] d_addr;
  logic [31:0] d_cfg;

  ddr3_dfi_init_seq dut_dflt (
    .clock(clock), .reset_n(d_reset_n), .restart_i(1'b0),
    .ctl_cs_n_i(1'b1), .ctl_ras_n_i(1'b1), .ctl_cas_n_i(1'b1),
    .ctl_we_n_i(1'b1), .ctl_odt_i(1'b0), .ctl_bank_i(3'd0),
    .ctl_address_i(14'd0), .ctl_ready_o(d_ready),
    .dfi_reset_n_o(d_reset_n_o), .dfi_cke_o(d_cke), .dfi_cs_n_o(d_cs_n),
    .dfi_ras_n_o(d_ras_n), .dfi_cas_n_o(d_cas_n), .dfi_we_n_o(d_we_n),
    .dfi_odt_o(d_odt), .dfi_bank_o(d_bank), .dfi_address_o(d_addr),
    .cfg_valid_o(d_cfg_valid), .cfg_o(d_cfg), .init_done_o(d_done)
  );

  int n_cmp = 0, n_bad = 0;
  int mk = 0;                 // model: cycle index within current sequence
  logic [31:0] m_cfg = '0;    // model: cfg_o contents
  bit dflt_done = 1'b0;

  // Observed event cycles for the directed timing checks.
  int ev_rst, ev_cke, ev_zq, ev_cfg, ev_done, n_mrs;
  int mrs_k[4];
  logic [2:0]  mrs_bank[4];
  logic [13:0] mrs_addr[4], zq_addr;
  logic [31:0] cfg_at_strobe;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic obs_t sample_dut();
    obs_t o;
    o.rst_n = dfi_reset_n_o;  o.cke = dfi_cke_o;
    o.cmd.cs_n = dfi_cs_n_o;  o.cmd.ras_n = dfi_ras_n_o;
    o.cmd.cas_n = dfi_cas_n_o; o.cmd.we_n = dfi_we_n_o;
    o.cmd.odt = dfi_odt_o;    o.cmd.bank = dfi_bank_o;
    o.cmd.addr = dfi_address_o;
    o.cfg_valid = cfg_valid_o; o.cfg = cfg_o;
    o.done = init_done_o;     o.ready = ctl_ready_o;
    return o;
  endfunction

  // Expected outputs at sequence cycle k when the controller is not forwarded.
  function automatic obs_t sched(input int k, input logic [31:0] cfg);
    obs_t o;
    o.rst_n = (k >= K_RST_UP);
    o.cke   = (k >= K_CKE_UP);
    o.cmd   = '{cs_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1,
                odt: 1'b0, bank: 3'd0, addr: 14'd0};
    if (o.cke) begin
      o.cmd.cs_n = 1'b0;
      if (k == K_MR2 || k == K_MR3 || k == K_MR1 || k == K_MR0) begin
        o.cmd.ras_n = 1'b0; o.cmd.cas_n = 1'b0; o.cmd.we_n = 1'b0;
        if (k == K_MR2) begin o.cmd.bank = 3'd2; o.cmd.addr = MR2_V; end
        if (k == K_MR3) begin o.cmd.bank = 3'd3; o.cmd.addr = MR3_V; end
        if (k == K_MR1) begin o.cmd.bank = 3'd1; o.cmd.addr = MR1_V; end
        if (k == K_MR0) begin o.cmd.bank = 3'd0; o.cmd.addr = MR0_V; end
      end else if (k == K_ZQ) begin
        o.cmd.we_n = 1'b0;
        o.cmd.addr = 14'h0400;
      end
    end
    o.cfg_valid = (k == K_CFG);
    o.cfg   = cfg;
    o.done  = (k >= K_DONE);
    o.ready = o.done;
    return o;
  endfunction

  function automatic cmd_t rand_cmd();
    logic [31:0] r;
    r = $urandom;
    return r[21:0];
  endfunction

  // Apply one cycle of inputs, advance the model, compare on the falling edge.
  task automatic step(input logic rs, input cmd_t c);
    bit   prev_done;
    obs_t exp, got;
    restart_i   = rs;
    ctl_cs_n_i  = c.cs_n;  ctl_ras_n_i = c.ras_n; ctl_cas_n_i = c.cas_n;
    ctl_we_n_i  = c.we_n;  ctl_odt_i   = c.odt;   ctl_bank_i  = c.bank;
    ctl_address_i = c.addr;
    @(posedge clock);
    prev_done = (mk >= K_DONE);
    if (prev_done && rs) mk = 0;
    else mk++;
    if (mk == K_CFG) m_cfg = CFG_WORD;
    exp = sched(mk, m_cfg);
    if (prev_done && !rs) exp.cmd = c;
    @(negedge clock);
    got = sample_dut();
    check($sformatf("cycle k=%0d", mk), 64'(got), 64'(exp));
    if (got.rst_n && ev_rst < 0) ev_rst = mk;
    if (got.cke && ev_cke < 0) ev_cke = mk;
    if (!got.cmd.cs_n && !got.cmd.ras_n && !got.cmd.cas_n && !got.cmd.we_n && n_mrs < 4) begin
      mrs_k[n_mrs] = mk; mrs_bank[n_mrs] = got.cmd.bank; mrs_addr[n_mrs] = got.cmd.addr;
      n_mrs++;
    end
    if (!got.cmd.cs_n && got.cmd.ras_n && got.cmd.cas_n && !got.cmd.we_n && ev_zq < 0) begin
      ev_zq = mk; zq_addr = got.cmd.addr;
    end
    if (got.cfg_valid && ev_cfg < 0) begin ev_cfg = mk; cfg_at_strobe = got.cfg; end
    if (got.done && ev_done < 0) ev_done = mk;
  endtask

  task automatic clear_events();
    ev_rst = -1; ev_cke = -1; ev_zq = -1; ev_cfg = -1; ev_done = -1; n_mrs = 0;
    zq_addr = '0; cfg_at_strobe = '0;
    for (int i = 0; i < 4; i++) begin mrs_k[i] = -1; mrs_bank[i] = '0; mrs_addr[i] = '0; end
  endtask

  // Full sequence with random (ignored) controller traffic and restarts,
  // followed by checks of the observed event cycles against the test plan.
  task automatic run_sequence(input string tag);
    int          exp_k[4] = '{24, 28, 32, 36};
    logic [2:0]  exp_b[4] = '{3'd2, 3'd3, 3'd1, 3'd0};
    logic [13:0] exp_a[4];
    exp_a[0] = MR2_V; exp_a[1] = MR3_V; exp_a[2] = MR1_V; exp_a[3] = MR0_V;
    clear_events();
    for (int i = 0; i < 72; i++)
      step(mk < K_DONE && $urandom_range(0, 3) == 0, rand_cmd());
    check({tag, " reset_n rise k"}, 64'(ev_rst),  64'(9));
    check({tag, " cke rise k"},     64'(ev_cke),  64'(19));
    check({tag, " mrs count"},      64'(n_mrs),   64'(4));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s mrs%0d k", tag, i),    64'(mrs_k[i]),    64'(exp_k[i]));
      check($sformatf("%s mrs%0d bank", tag, i), 64'(mrs_bank[i]), 64'(exp_b[i]));
      check($sformatf("%s mrs%0d addr", tag, i), 64'(mrs_addr[i]), 64'(exp_a[i]));
    end
    check({tag, " zqcl k"},         64'(ev_zq),   64'(48));
    check({tag, " zqcl addr"},      64'(zq_addr), 64'(14'h0400));
    check({tag, " cfg_valid k"},    64'(ev_cfg),  64'(68));
    check({tag, " cfg word"},       64'(cfg_at_strobe), 64'(32'h0000_0400));
    check({tag, " init_done k"},    64'(ev_done), 64'(69));
  endtask

  // Default-parameter instance: long reset and CKE waits.
  initial begin
    @(negedge clock); @(negedge clock);
    d_reset_n = 1'b1;
    for (int n = 1; n <= 70001; n++) begin
      @(negedge clock);
      if (n == 20000) check("dflt reset_n k=20000", 64'(d_reset_n_o), 64'(0));
      if (n == 20001) check("dflt reset_n k=20001", 64'(d_reset_n_o), 64'(1));
      if (n == 70000) check("dflt cke k=70000",     64'(d_cke),       64'(0));
      if (n == 70001) check("dflt cke k=70001",     64'(d_cke),       64'(1));
    end
    dflt_done = 1'b1;
  end

  initial begin
    cmd_t act;
    obs_t got;
    int   guard;
    clear_events();

    // Reset values while reset_n is held low.
    @(negedge clock);
    check("reset values", 64'(sample_dut()), 64'(sched(0, 32'h0)));
    @(negedge clock);
    reset_n = 1'b1;
    mk = 0;

    // Early part of the sequence: restart pulses (including at k=30) are
    // ignored, then an asynchronous reset lands mid-MRS at k=40.
    while (mk < 40) step((mk == 29) || ($urandom_range(0, 3) == 0), rand_cmd());
    #1 reset_n = 1'b0;
    #1 check("async reset mid-MRS", 64'(sample_dut()), 64'(sched(0, 32'h0)));
    @(negedge clock);
    check("held in reset", 64'(sample_dut()), 64'(sched(0, 32'h0)));
    reset_n = 1'b1;
    mk = 0;
    m_cfg = '0;

    // Full sequence after reset release.
    run_sequence("init");

    // Controller ACT forwarded one cycle later.
    act = '{cs_n: 1'b0, ras_n: 1'b0, cas_n: 1'b1, we_n: 1'b1, odt: 1'b0,
            bank: 3'd5, addr: 14'h1234};
    step(1'b0, act);
    got = sample_dut();
    check("ACT pass-through", 64'(got.cmd), 64'(act));

    // Restart from DONE: reset state on the next cycle, dropped command.
    step(1'b1, act);
    got = sample_dut();
    check("restart init_done", 64'(got.done),  64'(0));
    check("restart cke",       64'(got.cke),   64'(0));
    check("restart reset_n",   64'(got.rst_n), 64'(0));
    check("restart cs_n",      64'(got.cmd.cs_n), 64'(1));
    run_sequence("restart");

    // Mixed random traffic with occasional restarts from DONE.
    for (int i = 0; i < 800; i++)
      step((mk >= K_DONE) ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 3) == 0),
           rand_cmd());

    guard = 0;
    while (!dflt_done && guard < 80000) begin
      @(negedge clock);
      guard++;
    end
    check("default instance finished", 64'(dflt_done), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ddr3_dfi_init_seq.md
Name: ddr3_dfi_init_seq

Overview:
- Power-up and initialisation sequencer for the GW2A DDR3 DFI PHY.
- Drives the DFI control/command bus through the JEDEC DDR3 reset/CKE/MRS/ZQCL sequence using cycle counters.
- Pulses the PHY configuration word (read latency), then hands the DFI command bus to the memory controller via a registered pass-through mux.
- Sits between the memory controller and the PHY's dfi_* command inputs; the 100 MHz bus clock domain.

Parameters:
- ADDR_BITS, 14, DFI/DDR3 address width.
- RD_LAT, 4, read latency written to cfg_o[11:8].
- T_RESET, 20000, cycles dfi_reset_n_o held low (200 us).
- T_CKE, 50000, cycles from reset release to CKE high (500 us).
- T_XPR, 16, cycles from CKE high to first MRS.
- T_MRD, 4, cycles between consecutive MRS commands.
- T_MOD, 12, cycles from MR0 to ZQCL.
- T_ZQINIT, 512, cycles from ZQCL to configuration.
- MR0, 14'h0520, MR0 value.
- MR1, 14'h0004, MR1 value.
- MR2, 14'h0000, MR2 value.
- MR3, 14'h0000, MR3 value.

Ports:
- clock  in  1  100 MHz bus clock, the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- restart_i  in  1  request re-initialisation; honoured only when init_done_o=1.
- ctl_cs_n_i, ctl_ras_n_i, ctl_cas_n_i, ctl_we_n_i, ctl_odt_i  in  1 each  controller command.
- ctl_bank_i  in  3  controller bank.
- ctl_address_i  in  ADDR_BITS  controller address.
- ctl_ready_o  out  1  controller may issue commands; equals init_done_o.
- dfi_reset_n_o, dfi_cke_o, dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o, dfi_odt_o  out  1 each  to PHY.
- dfi_bank_o  out  3  to PHY.
- dfi_address_o  out  ADDR_BITS  to PHY.
- cfg_valid_o  out  1  one-cycle PHY configuration strobe.
- cfg_o  out  32  PHY configuration word.
- init_done_o  out  1  initialisation complete.

Behaviour:
- Timing and registers
  - Clock and reset: one clock (clock); reset_n is asynchronous, active-low.
  - All outputs are registered.
  - Reset values: dfi_reset_n_o=0, dfi_cke_o=0, cs_n/ras_n/cas_n/we_n=1, odt=0, bank=0, address=0, cfg_valid_o=0, cfg_o=0, init_done_o=0.
  - Asserting reset_n mid-sequence returns to these values immediately, with state RST.
- Command encodings (cs/ras/cas/we)
  - Deselect: cs_n=1.
  - NOP: 0111.
  - MRS: 0000, bank=MR index, address=MRx.
  - ZQCL: 0110, address[10]=1, other address bits 0.
- Command timing
  - Each command is driven for exactly one cycle.
  - NOPs are driven during every wait after CKE is high.
  - A single down-counter, at least 20 bits wide, is loaded with (wait−1) on state entry; the state advances when it reaches 0.
  - All T_* parameters must be ≥1.
- States and timing (cycle k = output after the k-th rising edge following reset_n release, first edge = 1)
  - RST: reset_n=0, cke=0, deselect; dwell T_RESET cycles.
  - CKEW: dfi_reset_n_o=1, cke=0, deselect; dwell T_CKE.
  - XPR: cke=1, NOP; dwell T_XPR.
  - MRS2 → MRS3 → MRS1 → MRS0: each issues one MRS, followed by T_MRD cycles (T_MOD after MR0) measured command-to-command.
  - ZQ: ZQCL, followed by T_ZQINIT cycles.
  - CFG: cfg_valid_o=1 for one cycle; cfg_o = {20'b0, RD_LAT[3:0], 8'b0}; cfg_o holds this value afterwards.
  - DONE: init_done_o=1 from the cycle after CFG.
- DONE state
  - dfi command/bank/address/odt = ctl_* registered, one-cycle latency.
  - dfi_cke_o=1 and dfi_reset_n_o=1 are held.
- Before DONE, ctl_* inputs are ignored.
- restart_i
  - In DONE: the next edge enters RST with init_done_o=0, cke=0, reset_n=0, deselect; a ctl command on that same edge is dropped.
  - Outside DONE: ignored.
- cfg_valid_o never asserts outside CFG.

Test Plan:
- Small parameters (T_RESET=8, T_CKE=10, T_XPR=5, T_MRD=4, T_MOD=12, T_ZQINIT=20), release reset_n → dfi_reset_n_o rises at k=9, dfi_cke_o at k=19, MR2 at k=24, MR3 at k=28, MR1 at k=32, MR0 at k=36, ZQCL at k=48, cfg_valid_o at k=68 with cfg_o=32'h0000_0400, init_done_o at k=69.
- Check MRS payloads → bank=2,3,1,0 with address=MR2,MR3,MR1,MR0; ZQCL has address=14'h0400; every non-command cycle after k=19 is NOP.
- After done, drive ctl ACT (cs0 ras0 cas1 we1, bank=5, addr=14'h1234) → identical on dfi_* one cycle later; ctl inputs toggled before done → dfi outputs unchanged.
- Pulse restart_i in DONE → next cycle init_done_o=0, dfi_cke_o=0, dfi_reset_n_o=0; full sequence repeats with identical timing; restart_i pulsed at k=30 of the initial sequence → no effect.
- Assert reset_n low at k=40 (mid-MRS) → outputs take reset values asynchronously; on release, sequence restarts from k=1.
- Default parameters → dfi_reset_n_o rises at k=20001, dfi_cke_o at k=70001, confirming no counter overflow.
